// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and a constant-width helper
// used to size the iteration counter.
package seq_mult_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Ceiling log2, for elaboration-time sizing only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_unit_datapath.sv
// Shift-add multiplier datapath: acc/mcand/mplier registers plus product register.
// Ports: ld loads |A|,|B| and the result sign; add_shift does one add-and-shift step;
//        sign_fix writes the (optionally negated) {acc,mplier} to product.
module seq_mult_unit_datapath
  import seq_mult_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               add_shift,
  input  logic               sign_fix,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   acc_q, mcand_q, mplier_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  always_comb begin
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    // Unsigned W-bit view of the magnitude: -2^(W-1) maps to 2^(W-1) without overflow.
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
    // Extra MSB captures the carry that is shifted back into the accumulator.
    sum   = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    raw   = {acc_q, mplier_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      if (ld) begin
        acc_q    <= '0;
        mcand_q  <= a_abs;
        mplier_q <= b_abs;
        neg_q    <= a_neg ^ b_neg;
      end else if (add_shift) begin
        acc_q    <= sum[WIDTH:1];
        mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
      end
      if (sign_fix) begin
        // A zero magnitude never gets negated.
        prod_q <= (neg_q && (raw != '0)) ? -raw : raw;
      end
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier with valid/ready handshake, optional signed mode.
// Ports: in_valid/in_ready + operands in, out_valid/out_ready + product_out, busy.
// Result appears WIDTH+1 cycles after accept and is held until out_ready.
module seq_mult_unit
  import seq_mult_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_out,
  output logic               busy
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld, add_shift, sign_fix;
  logic          sgn;

  assign sgn = SIGNED_EN & is_signed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld        = 1'b0;
    add_shift = 1'b0;
    sign_fix  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          ld      = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        add_shift = 1'b1;
        if (cnt_q == '0) state_d = ST_SIGN;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_SIGN: begin
        sign_fix = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seq_mult_unit_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .add_shift (add_shift),
    .sign_fix  (sign_fix),
    .a         (multiplicand_in),
    .b         (multiplier_in),
    .sgn       (sgn),
    .product   (product_out)
  );

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] in_valid, out_ready;
  wire  [2:0] in_ready, out_valid, busy;
  logic [7:0] op_a, op_b;
  logic       sgn_in;
  wire  [7:0]  p4;
  wire  [15:0] p8s, p8u;

  // 0: WIDTH=4 signed-capable, 1: WIDTH=8 signed-capable, 2: WIDTH=8 unsigned-only
  seq_mult_unit #(.WIDTH(4), .SIGNED_EN(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .multiplicand_in(op_a[3:0]), .multiplier_in(op_b[3:0]), .is_signed(sgn_in),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product_out(p4), .busy(busy[0]));

  seq_mult_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) u_w8s (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .multiplicand_in(op_a), .multiplier_in(op_b), .is_signed(sgn_in),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product_out(p8s), .busy(busy[1]));

  seq_mult_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) u_w8u (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .multiplicand_in(op_a), .multiplier_in(op_b), .is_signed(sgn_in),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .product_out(p8u), .busy(busy[2]));

  typedef struct {
    int          dut;
    logic [15:0] exp;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [2:0] ov_prev = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] prod_of(input int i);
    case (i)
      0:       return {8'h00, p4};
      1:       return p8s;
      default: return p8u;
    endcase
  endfunction

  function automatic int wid_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (op %0d): got %0h, want %0h", nm, id, act, exp);
  endtask

  // Monitor: latency on the rising edge of out_valid, product on each take.
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst && out_valid[i] && !ov_prev[i]) begin
        if (sb.size() == 0 || sb[0].dut != i)
          chk("result_expected", i, {31'd0, (sb.size() > 0)}, 32'd1);
        else
          chk("latency", sb[0].id, cyc - sb[0].acc, wid_of(i) + 1);
      end
      if (!rst && out_valid[i] && out_ready[i] && sb.size() > 0 && sb[0].dut == i) begin
        chk("product", sb[0].id, {16'd0, prod_of(i)}, {16'd0, sb[0].exp});
        void'(sb.pop_front());
      end
      ov_prev[i] = out_valid[i] && !rst;
    end
  end

  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input int id, output int acc);
    int   t;
    exp_t e;
    t = 0;
    acc = 0;
    op_a = a; op_b = b; sgn_in = s; in_valid[d] = 1'b1;
    while (!in_ready[d] && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      chk("accept_timeout", id, t, 0);
    end else begin
      e.dut = d; e.exp = exp; e.acc = cyc + 1; e.id = id;
      acc = e.acc;
      sb.push_back(e);
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("drain_timeout", 0, sb.size(), 0);
  endtask

  initial begin
    int a0, a1, a2, t;
    logic [7:0] vec_a [9];
    logic [7:0] vec_b [9];
    logic       vec_s [9];
    logic [15:0] vec_p [9];
    int          vec_d [9];
    // dut, A, B, signed, expected
    vec_d[0]=0; vec_a[0]=8'h05; vec_b[0]=8'h0B; vec_s[0]=0; vec_p[0]=16'h0037; // 5*11
    vec_d[1]=0; vec_a[1]=8'h08; vec_b[1]=8'h08; vec_s[1]=1; vec_p[1]=16'h0040; // -8*-8
    vec_d[2]=0; vec_a[2]=8'h08; vec_b[2]=8'h07; vec_s[2]=1; vec_p[2]=16'h00C8; // -8*7
    vec_d[3]=1; vec_a[3]=8'hFD; vec_b[3]=8'h07; vec_s[3]=1; vec_p[3]=16'hFFEB; // -3*7
    vec_d[4]=1; vec_a[4]=8'hFD; vec_b[4]=8'h07; vec_s[4]=0; vec_p[4]=16'h06EB; // 253*7
    vec_d[5]=1; vec_a[5]=8'h80; vec_b[5]=8'h80; vec_s[5]=1; vec_p[5]=16'h4000; // -128*-128
    vec_d[6]=1; vec_a[6]=8'h80; vec_b[6]=8'h7F; vec_s[6]=1; vec_p[6]=16'hC080; // -128*127
    vec_d[7]=1; vec_a[7]=8'hFF; vec_b[7]=8'hFF; vec_s[7]=0; vec_p[7]=16'hFE01; // 255*255
    vec_d[8]=1; vec_a[8]=8'h00; vec_b[8]=8'hFB; vec_s[8]=1; vec_p[8]=16'h0000; // 0*-5

    rst = 1'b1; in_valid = 3'b000; out_ready = 3'b111;
    op_a = 8'h00; op_b = 8'h00; sgn_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready",  i, {31'd0, in_ready[i]},  1);
      chk("rst_out_valid", i, {31'd0, out_valid[i]}, 0);
      chk("rst_busy",      i, {31'd0, busy[i]},      0);
      chk("rst_product",   i, {16'd0, prod_of(i)},   0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++)
      issue(vec_d[k], vec_a[k], vec_b[k], vec_s[k], vec_p[k], k + 1, a0);
    issue(1, 8'h00, 8'hC8, 1'b0, 16'h0000, 10, a0);  // 0*200
    drain();

    // Backpressure: result held, no second accept.
    out_ready[1] = 1'b0;
    issue(1, 8'h0C, 8'h0D, 1'b0, 16'h009C, 20, a0);
    t = 0;
    while (!out_valid[1] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("bp_timeout", 20, t, 0);
    for (int k = 0; k < 10; k++) begin
      in_valid[1] = k[0];
      @(negedge clk);
      chk("bp_product",   20, {16'd0, p8s},         32'h009C);
      chk("bp_in_ready",  20, {31'd0, in_ready[1]}, 0);
      chk("bp_busy",      20, {31'd0, busy[1]},     1);
      chk("bp_out_valid", 20, {31'd0, out_valid[1]}, 1);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    drain();
    repeat (15) @(negedge clk);
    chk("bp_no_extra", 20, {31'd0, out_valid[1]}, 0);

    // Reset mid-CALC discards the operation.
    issue(1, 8'h09, 8'h09, 1'b0, 16'h0051, 30, a0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready",  30, {31'd0, in_ready[1]},  1);
    chk("midrst_out_valid", 30, {31'd0, out_valid[1]}, 0);
    chk("midrst_product",   30, {16'd0, p8s},          0);
    rst = 1'b0;
    @(negedge clk);
    issue(1, 8'h06, 8'h07, 1'b0, 16'h002A, 31, a0);
    drain();

    // SIGNED_EN=0 ignores is_signed; back-to-back issue interval.
    issue(2, 8'hFD, 8'h07, 1'b1, 16'h06EB, 40, a0);
    issue(2, 8'hFF, 8'h02, 1'b1, 16'h01FE, 41, a1);
    issue(2, 8'h80, 8'h81, 1'b1, 16'h4080, 42, a2);
    chk("interval_1", 41, a1 - a0, 11);
    chk("interval_2", 42, a2 - a1, 11);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
